// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences the 2-way set-associative cache data array against
// word-wide main memory. Probes the array, services hits, writes back a
// dirty victim block word by word, refills the missing block, then reprobes.
module cache_ctrl #(
  parameter int ADDR_BITS           = 32,
  parameter int TAG_BITS            = 23,
  parameter int SET_INDEX_WIDTH     = 5,
  parameter int ELEMENT_WORDS_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] cpu_addr,
  input  logic                 cpu_rd,
  input  logic                 cpu_wr,
  input  logic [2:0]           cpu_ubhw,
  input  logic [31:0]          cpu_wdata,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_done,
  output logic                 cpu_stall,
  output logic [ADDR_BITS-1:0] cache_addr,
  output logic                 cache_load,
  output logic                 cache_store,
  output logic                 cache_edit,
  output logic                 cache_invalid,
  output logic [2:0]           cache_ubhw,
  output logic [31:0]          cache_din,
  input  logic                 cache_hit,
  input  logic                 cache_valid,
  input  logic                 cache_dirty,
  input  logic [TAG_BITS-1:0]  cache_tag,
  input  logic [31:0]          cache_dout,
  output logic                 mem_cs,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [31:0]          mem_wdata,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack
);

  localparam int IDX_LO = ELEMENT_WORDS_WIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_PROBE, S_RESP, S_WB_RD, S_WB_WR, S_FILL, S_REPROBE
  } state_t;

  state_t                         state, state_nx;
  logic [ELEMENT_WORDS_WIDTH-1:0] cnt, cnt_nx;
  logic [ADDR_BITS-1:0]           req_addr;
  logic                           req_wr;
  logic [2:0]                     req_ubhw;
  logic [31:0]                    req_wdata;
  logic [TAG_BITS-1:0]            victim_tag;
  logic [SET_INDEX_WIDTH-1:0]     req_idx;
  logic [ADDR_BITS-1:0]           wb_addr, fill_addr;

  assign req_idx   = req_addr[IDX_LO +: SET_INDEX_WIDTH];
  assign wb_addr   = {victim_tag, req_idx, cnt, 2'b00};
  assign fill_addr = {req_addr[ADDR_BITS-1 -: TAG_BITS], req_idx, cnt, 2'b00};

  // State, word counter, request capture and victim tag capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      req_addr   <= '0;
      req_wr     <= 1'b0;
      req_ubhw   <= '0;
      req_wdata  <= '0;
      victim_tag <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (state == S_IDLE && (cpu_rd || cpu_wr)) begin
        req_addr  <= cpu_addr;
        req_wr    <= cpu_wr;      // write wins when both are raised
        req_ubhw  <= cpu_ubhw;
        req_wdata <= cpu_wdata;
      end
      if (state == S_PROBE && !cache_hit && cache_valid && cache_dirty)
        victim_tag <= cache_tag;
    end
  end

  // Next state and all outputs; everything stays 0 while rst is high so
  // nothing leaks to the array or memory during the reset cycle
  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    cpu_rdata     = '0;
    cpu_done      = 1'b0;
    cpu_stall     = 1'b0;
    cache_addr    = '0;
    cache_load    = 1'b0;
    cache_store   = 1'b0;
    cache_edit    = 1'b0;
    cache_invalid = 1'b0;
    cache_ubhw    = '0;
    cache_din     = '0;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          cache_addr = cpu_addr;   // array flags are ready in PROBE
          cache_ubhw = cpu_ubhw;
          cpu_stall  = cpu_rd | cpu_wr;
          if (cpu_rd || cpu_wr) state_nx = S_PROBE;
        end
        S_PROBE: begin
          cpu_stall  = 1'b1;
          cache_addr = req_addr;
          cache_ubhw = req_ubhw;
          if (cache_hit) begin
            if (req_wr) begin
              cache_edit = 1'b1;
              cache_din  = req_wdata;
            end else begin
              cache_load = 1'b1;
            end
            state_nx = S_RESP;
          end else begin
            cnt_nx   = '0;
            state_nx = (cache_valid && cache_dirty) ? S_WB_RD : S_FILL;
          end
        end
        S_RESP: begin
          cpu_stall  = 1'b1;
          cpu_done   = 1'b1;
          cache_addr = req_addr;
          cpu_rdata  = req_wr ? '0 : cache_dout;
          state_nx   = S_IDLE;
        end
        S_WB_RD: begin
          // present the victim word; registered dout carries it next cycle
          cpu_stall  = 1'b1;
          cache_addr = wb_addr;
          state_nx   = S_WB_WR;
        end
        S_WB_WR: begin
          cpu_stall  = 1'b1;
          cache_addr = wb_addr;    // keeps dout stable while memory waits
          mem_cs     = 1'b1;
          mem_we     = 1'b1;
          mem_addr   = wb_addr;
          mem_wdata  = cache_dout;
          if (mem_ack) begin
            cnt_nx   = cnt + 1'b1;
            state_nx = (cnt == '1) ? S_FILL : S_WB_RD;
          end
        end
        S_FILL: begin
          cpu_stall  = 1'b1;
          cache_addr = fill_addr;
          cache_ubhw = req_ubhw;
          mem_cs     = 1'b1;
          mem_addr   = fill_addr;
          if (mem_ack) begin
            cache_store = 1'b1;
            cache_din   = mem_rdata;
            cnt_nx      = cnt + 1'b1;
            if (cnt == '1) state_nx = S_REPROBE;
          end
        end
        S_REPROBE: begin
          // one idle cycle so the flags reflect the refilled block
          cpu_stall  = 1'b1;
          cache_addr = req_addr;
          state_nx   = S_PROBE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule
